// File: rtl/div_unit_32bit.sv
// div_unit_32bit: iterative radix-2 restoring divider for DIV, DIVU, REM and REMU.
// One quotient bit per cycle through a shared adder_subtractor_32bit; start/busy/valid
// handshake with flush abort.
// Optional build macro: DIV_EARLY_OUT_EN. When defined, divide-by-zero and INT_MIN/-1 are
// resolved straight from the operands on accept (IDLE -> DONE), skipping the iteration.
// Results are identical in both builds; only latency differs.

module div_unit_32bit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_valid,
    output logic [31:0] o_result
);

    // i_op[1] selects remainder, i_op[0] selects unsigned
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] q_reg, r_reg, d_reg, result_reg;
    logic [4:0]  cnt;
    logic        is_rem, neg_q, neg_r, b_zero;

    logic        op_signed, accept;
    logic [31:0] a_mag, b_mag;
    logic [31:0] step_s, add_a, add_b, add_res;
    logic        add_carry, adder_overflow_unused, take;
    logic [31:0] q_fix, r_fix, fix_result;

    assign op_signed = ~i_op[0];
    // flush has priority over a same-edge start
    assign accept    = (state == IDLE) && i_start && !i_flush;
    assign a_mag     = (op_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
    assign b_mag     = (op_signed && i_b[31]) ? (32'd0 - i_b) : i_b;

    adder_subtractor_32bit u_addsub (
        .i_a        (add_a),
        .i_b        (add_b),
        .i_sub      (1'b1),
        .o_result   (add_res),
        .o_carry    (add_carry),
        .o_overflow (adder_overflow_unused)
    );

    // Shifted partial remainder; adder operands are gated to zero outside CALC
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        step_s = {r_reg[30:0], q_reg[31]};
        add_a  = 32'd0;
        add_b  = 32'd0;
        if (state == CALC) begin
            add_a = step_s;
            add_b = d_reg;
        end
    end

    // R[31]=1 means the 33-bit shifted value already exceeds any 32-bit divisor
    assign take = r_reg[31] | add_carry;

    // Sign correction; with b==0 the remainder path naturally yields the dividend
    always_comb begin
        q_fix      = neg_q ? (32'd0 - q_reg) : q_reg;
        r_fix      = neg_r ? (32'd0 - r_reg) : r_reg;
        fix_result = is_rem ? r_fix : (b_zero ? 32'hFFFF_FFFF : q_fix);
    end

`ifdef DIV_EARLY_OUT_EN
    logic        early_hit;
    logic [31:0] early_result;

    // Detect the two special cases directly on the input operands
    always_comb begin
        early_hit = (i_b == 32'd0) ||
                    (op_signed && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF));
        if (i_b == 32'd0) early_result = i_op[1] ? i_a : 32'hFFFF_FFFF;
        else              early_result = i_op[1] ? 32'd0 : 32'h8000_0000;
    end
`endif

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
`ifdef DIV_EARLY_OUT_EN
                    state_nxt = early_hit ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (i_flush)          state_nxt = IDLE;
                else if (cnt == 5'd0) state_nxt = FIXUP;
            end
            FIXUP:   state_nxt = i_flush ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Datapath registers: operand capture, restoring step, result write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_reg      <= 32'd0;
            r_reg      <= 32'd0;
            d_reg      <= 32'd0;
            result_reg <= 32'd0;
            cnt        <= 5'd0;
            is_rem     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            b_zero     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        is_rem <= i_op[1];
                        neg_q  <= op_signed & (i_a[31] ^ i_b[31]);
                        neg_r  <= op_signed & i_a[31];
                        b_zero <= (i_b == 32'd0);
                        q_reg  <= a_mag;
                        d_reg  <= b_mag;
                        r_reg  <= 32'd0;
                        cnt    <= 5'd31;
`ifdef DIV_EARLY_OUT_EN
                        if (early_hit) result_reg <= early_result;
`endif
                    end
                end
                CALC: begin
                    r_reg <= take ? add_res : step_s;
                    q_reg <= {q_reg[30:0], take};
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                FIXUP: begin
                    if (!i_flush) result_reg <= fix_result;
                end
                default: ;
            endcase
        end
    end

    assign o_busy   = (state != IDLE);
    assign o_valid  = (state == DONE);
    assign o_result = result_reg;

endmodule

// 32-bit adder/subtractor: i_sub=1 computes i_a - i_b; o_carry=1 means no borrow (i_a >= i_b).
module adder_subtractor_32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_sub,
    output logic [31:0] o_result,
    output logic        o_carry,
    output logic        o_overflow
);

    logic [31:0] b_eff;
    logic [32:0] sum;

    // Two's-complement add of optionally inverted operand with carry-in
    always_comb begin
        b_eff      = i_sub ? ~i_b : i_b;
        sum        = {1'b0, i_a} + {1'b0, b_eff} + {32'd0, i_sub};
        o_result   = sum[31:0];
        o_carry    = sum[32];
        o_overflow = (i_a[31] == b_eff[31]) && (sum[31] != i_a[31]);
    end

endmodule

// File: tb/tb_div_unit_32bit.sv
// tb_div_unit_32bit: scoreboard bench for div_unit_32bit (either DIV_EARLY_OUT_EN build).
// Latency is counted in edges including the accept edge: 34 normally, 1 for early-out.

module tb_div_unit_32bit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy, valid;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   accept_cyc = 0;

    div_unit_32bit dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .i_flush  (flush),
        .o_busy   (busy),
        .o_valid  (valid),
        .o_result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model, written from the instruction semantics
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx, sy;
        sx = x;
        sy = y;
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            OP_DIV:  return sx / sy;
            OP_DIVU: return x / y;
            OP_REM:  return sx % sy;
            default: return x % y;
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        bit special;
        special = (y == 32'd0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
        return special ? 1 : 34;
`else
        return special ? 34 : 34;
`endif
    endfunction

    // Called at a negedge: waits for idle, drives one start pulse, pushes the expectation
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp_res);
        exp_t e;
        int   n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL launch_idle: o_busy=%b required 0", busy);
        end
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        e.res = exp_res;
        e.lat = exp_latency(o, x, y);
        sb.push_back(e);
        accept_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for o_valid, pops the scoreboard, checks result, latency and pulse width.
    // poke_done drives i_start during the DONE cycle, which must be ignored.
    task automatic collect(input string tag, input bit poke_done);
        exp_t e;
        int   n = 0;
        int   lat;
        while (valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (valid !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL %s_timeout: o_valid=%b required 1 (queued=%0d)", tag, valid, sb.size());
            if (sb.size() > 0) e = sb.pop_front();
            return;
        end
        e   = sb.pop_front();
        lat = cyc - accept_cyc + 1;
        if (lat !== e.lat) begin
            bad++;
            $display("FAIL %s_latency: got %0d edges required %0d", tag, lat, e.lat);
        end
        total++;
        if (result !== e.res) begin
            bad++;
            $display("FAIL %s_result: got 0x%08h required 0x%08h", tag, result, e.res);
        end
        if (poke_done) begin
            start = 1'b1;
            op    = OP_DIVU;
            a     = 32'd77;
            b     = 32'd5;
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_pulse: o_valid=%b o_busy=%b required 0 0", tag, valid, busy);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        launch(o, x, y, ref_result(o, x, y));
        collect(tag, 1'b0);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", valid); end
        total++;
        if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got 0x%08h required 0", result); end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %b required 0", busy); end
    endtask

    logic [1:0]  d_op  [10] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM};
    logic [31:0] d_a   [10] = '{32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b   [10] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd1, 32'hFFFF_FFFF,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp [10] = '{32'd14, 32'd2, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0,
                                32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

    task automatic test_directed;
        for (int i = 0; i < 10; i++) begin
            launch(d_op[i], d_a[i], d_b[i], d_exp[i]);
            collect($sformatf("directed%0d", i), 1'b0);
        end
    endtask

    task automatic test_ignore_and_flush;
        exp_t        e;
        logic [31:0] held;
        bit          seen = 1'b0;
        held = result;
        launch(OP_DIVU, 32'd9, 32'd2, 32'd4);
        while (cyc < accept_cyc + 9) @(negedge clk);
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd7;
        b     = 32'd1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_start_ignored: o_busy=%b required 1", busy); end
        while (cyc < accept_cyc + 19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle: o_busy=%b o_valid=%b required 0 0", busy, valid);
        end
        total++;
        if (result !== held) begin bad++; $display("FAIL flush_result_held: got 0x%08h required 0x%08h", result, held); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL flush_no_valid: o_valid rose after flush, required none"); end
        if (sb.size() > 0) e = sb.pop_front();
        run_op("after_flush", OP_DIVU, 32'd100, 32'd7);
    endtask

    task automatic test_reset_mid_op;
        exp_t e;
        bit   seen = 1'b0;
        launch(OP_REMU, 32'd1000, 32'd3, 32'd1);
        while (cyc < accept_cyc + 14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_ctrl: o_busy=%b o_valid=%b required 0 0", busy, valid);
        end
        total++;
        if (result !== 32'd0) begin bad++; $display("FAIL reset_mid_result: got 0x%08h required 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL reset_mid_no_valid: o_valid rose after reset, required none"); end
        if (sb.size() > 0) e = sb.pop_front();
    endtask

    task automatic test_back_to_back;
        launch(OP_DIV, 32'hFFFF_FC18, 32'd10, ref_result(OP_DIV, 32'hFFFF_FC18, 32'd10));
        collect("b2b_first", 1'b1);
        launch(OP_REM, 32'd12345, 32'hFFFF_FFF9, ref_result(OP_REM, 32'd12345, 32'hFFFF_FFF9));
        collect("b2b_second", 1'b0);
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] x, y;
        int          sel;
        for (int i = 0; i < 1500; i++) begin
            o   = 2'($urandom_range(0, 3));
            x   = $urandom;
            sel = $urandom_range(0, 99);
            if (sel == 0)      y = 32'd0;
            else if (sel < 15) y = $urandom_range(1, 15);
            else if (sel < 20) y = 32'hFFFF_FFFF - $urandom_range(0, 3);
            else               y = $urandom;
            if (sel == 99) x = 32'h8000_0000;
            run_op($sformatf("random%0d", i), o, x, y);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_and_flush();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
